// File: rtl/reg_serial_pkg.sv
// Shared state encoding and line levels for the serial transmitter.
package reg_serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/reg_serial_bit_timer.sv
// Bit-time counter: pulses bit_done on the last clock of every bit while run is high.
module reg_serial_bit_timer #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_,
  input  logic run,
  output logic bit_done
);

  localparam int unsigned CW = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      cnt <= '0;
    else if (!run || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign bit_done = run && (cnt == LAST);

endmodule

// File: rtl/reg_serial_tx.sv
// Byte-to-serial transmitter: start(0), data LSB first, stop(1), each bit BIT_CYCLES clocks.
// Define REG_SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module reg_serial_tx
  import reg_serial_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] data,
  input  logic              enable,
  output logic              ready,
  output logic              busy,
  output logic              tx
);

  localparam int unsigned IW = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              load;
  logic              bit_done;

  assign load = enable && ready_q;

  reg_serial_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_     (rst_),
    .run      (state_q != IDLE),
    .bit_done (bit_done)
  );

`ifdef REG_SERIAL_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      par_q <= 1'b0;
    else if (state_q == IDLE && load)
      par_q <= ^data;
  end
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= IDLE_LEVEL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = START;
          shift_d = data;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef REG_SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line changes on the same edge as the state.
  always_comb begin
    tx_d    = IDLE_LEVEL;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    case (state_d)
      IDLE:   tx_d = IDLE_LEVEL;
      START:  tx_d = START_LEVEL;
      DATA:   tx_d = shift_d[0];
`ifdef REG_SERIAL_TX_PARITY_EN
      PARITY: tx_d = par_q;
`else
      PARITY: tx_d = STOP_LEVEL;
`endif
      STOP:   tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_reg_serial_tx.sv
// Directed self-checking bench for reg_serial_tx (BIT_CYCLES=4, DATA_W=8).
module tb_reg_serial_tx;

  localparam int BC = 4;
`ifdef REG_SERIAL_TX_PARITY_EN
  localparam int FB = 11;
  // slot order from bit 0: start, d0..d7, parity, stop
  localparam logic [FB-1:0] P_AA = 11'b1_0_10101010_0;
  localparam logic [FB-1:0] P_55 = 11'b1_0_01010101_0;
  localparam logic [FB-1:0] P_00 = 11'b1_0_00000000_0;
  localparam logic [FB-1:0] P_FF = 11'b1_0_11111111_0;
  localparam logic [FB-1:0] P_07 = 11'b1_1_00000111_0;
  localparam logic [FB-1:0] P_03 = 11'b1_0_00000011_0;
`else
  localparam int FB = 10;
  localparam logic [FB-1:0] P_AA = 10'b1_10101010_0;
  localparam logic [FB-1:0] P_55 = 10'b1_01010101_0;
  localparam logic [FB-1:0] P_00 = 10'b1_00000000_0;
  localparam logic [FB-1:0] P_FF = 10'b1_11111111_0;
`endif

  logic       clk;
  logic       rst_;
  logic [7:0] data;
  logic       enable;
  logic       ready;
  logic       busy;
  logic       tx;

  int n_asserts = 0;
  int n_fail    = 0;

  reg_serial_tx #(
    .DATA_W     (8),
    .BIT_CYCLES (BC)
  ) dut (
    .clk    (clk),
    .rst_   (rst_),
    .data   (data),
    .enable (enable),
    .ready  (ready),
    .busy   (busy),
    .tx     (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    enable = 1'b0;
    data   = 'x;
    chk({name, " tx"},    tx,    1'b1);
    chk({name, " ready"}, ready, 1'b1);
    chk({name, " busy"},  busy,  1'b0);
  endtask

  // caller must be at a negedge; load is accepted on the following posedge
  task automatic load(input logic [7:0] d);
    data   = d;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    data   = 'x;
  endtask

  task automatic check_frame(input logic [FB-1:0] pat, input int inject, input int ncyc,
                             input string name);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == inject) begin
        enable = 1'b1;
        data   = 8'hFF;
      end else begin
        enable = 1'b0;
        data   = 'x;
      end
      chk($sformatf("%s tx c%0d", name, c),    tx,    pat[c / BC]);
      chk($sformatf("%s busy c%0d", name, c),  busy,  1'b1);
      chk($sformatf("%s ready c%0d", name, c), ready, 1'b0);
    end
  endtask

  initial begin
    rst_   = 1'b0;
    data   = 'x;
    enable = 1'bx;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst tx",    tx,    1'b1);
      chk("rst ready", ready, 1'b1);
      chk("rst busy",  busy,  1'b0);
    end
    rst_   = 1'b1;
    enable = 1'b0;
    repeat (3) check_idle("post-rst idle");

    load(8'hAA);
    check_frame(P_AA, -1, FB * BC, "frame AA");
    check_idle("after AA");

    load(8'h55);
    check_frame(P_55, 12, FB * BC, "frame 55 ignore");
    check_idle("after 55");
    check_idle("55 no requeue");

    load(8'h00);
    check_frame(P_00, -1, FB * BC, "b2b 00");
    check_idle("b2b gap");
    load(8'hFF);
    check_frame(P_FF, -1, FB * BC, "b2b FF");
    check_idle("after FF");

    load(8'hAA);
    check_frame(P_AA, -1, 17, "midrst AA");
    @(posedge clk);
    #2 rst_ = 1'b0;
    #1;
    chk("midrst tx",    tx,    1'b1);
    chk("midrst ready", ready, 1'b1);
    chk("midrst busy",  busy,  1'b0);
    @(negedge clk);
    rst_ = 1'b1;
    check_idle("midrst idle");
    load(8'h55);
    check_frame(P_55, -1, FB * BC, "post-midrst 55");
    check_idle("after post-midrst");

`ifdef REG_SERIAL_TX_PARITY_EN
    load(8'h07);
    check_frame(P_07, -1, FB * BC, "parity 07");
    check_idle("after 07");
    load(8'h03);
    check_frame(P_03, -1, FB * BC, "parity 03");
    check_idle("after 03");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
